dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter_pkg.sv | 14 +
 rtl/dmem_arb_wdog.sv | 31 +++
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter between the core and the debug/DMA port.
package dmem_arbiter_pkg;

  localparam int unsigned STALL_MAX_DEF = 15;

  // Each state names the owner of the most recently granted cycle.
  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_CORE,
    ARB_DBG,
    ARB_DBG_LOCK
  } arb_state_e;

endpackage

// File: rtl/dmem_arb_wdog.sv
// Core starvation watchdog: counts the cycles the core waits without a grant and
// flags expiry once the count reaches STALL_MAX.
module dmem_arb_wdog #(
  parameter int unsigned STALL_MAX = 15
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic waiting,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = (STALL_MAX > 0) ? $clog2(STALL_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(STALL_MAX);

  logic [CNT_W-1:0] count_q;

  // Saturates at the limit so a long stall cannot wrap the counter back to zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (waiting && (count_q != MAX_CNT)) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign expired = (count_q == MAX_CNT);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter. Grants alternate on conflict, the debug port can hold
// a lock, and a watchdog breaks locks that starve the core.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned STALL_MAX = STALL_MAX_DEF
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              c_req_i,
  input  logic              c_we_i,
  input  logic [ADDR_W-1:0] c_addr_i,
  input  logic [31:0]       c_wdata_i,
  input  logic [3:0]        c_bmask_i,
  output logic              c_gnt_o,
  output logic              c_rvalid_o,
  output logic [31:0]       c_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  input  logic [3:0]        d_bmask_i,
  input  logic              d_lock_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic              m_wren_o,
  output logic [ADDR_W-1:0] m_addr_o,
  output logic [31:0]       m_wdata_o,
  output logic [3:0]        m_bmask_o,
  input  logic [31:0]       m_rdata_i,
  output logic              starve_o
);

  arb_state_e state_q, state_d;
  logic       c_gnt, d_gnt, starve, lock_active;
  logic       wdog_expired;
  logic       rsp_valid_q, rsp_dbg_q;

  dmem_arb_wdog #(
    .STALL_MAX(STALL_MAX)
  ) u_wdog (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .waiting(c_req_i & ~c_gnt),
    .clear  (c_gnt),
    .expired(wdog_expired)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ARB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Priority: watchdog override, then an active lock, then alternation on conflict.
  // Grants are held low while reset is asserted so nothing leaks out combinationally.
  always_comb begin
    c_gnt       = 1'b0;
    d_gnt       = 1'b0;
    starve      = 1'b0;
    state_d     = ARB_IDLE;
    lock_active = (state_q == ARB_DBG_LOCK) && d_req_i && d_lock_i;
    if (rst_ni) begin
      if (c_req_i && wdog_expired) begin
        c_gnt  = 1'b1;
        starve = 1'b1;
      end else if (lock_active) begin
        d_gnt = 1'b1;
      end else if (c_req_i && d_req_i) begin
        if (state_q == ARB_CORE) begin
          d_gnt = 1'b1;
        end else begin
          c_gnt = 1'b1;
        end
      end else if (c_req_i) begin
        c_gnt = 1'b1;
      end else if (d_req_i) begin
        d_gnt = 1'b1;
      end
    end
    if (c_gnt) begin
      state_d = ARB_CORE;
    end else if (d_gnt) begin
      state_d = d_lock_i ? ARB_DBG_LOCK : ARB_DBG;
    end
  end

  always_comb begin
    m_addr_o  = '0;
    m_wdata_o = '0;
    m_bmask_o = '0;
    m_wren_o  = 1'b0;
    if (c_gnt) begin
      m_addr_o  = c_addr_i;
      m_wdata_o = c_wdata_i;
      m_bmask_o = c_bmask_i;
      m_wren_o  = c_we_i && (c_bmask_i != 4'b0000);
    end else if (d_gnt) begin
      m_addr_o  = d_addr_i;
      m_wdata_o = d_wdata_i;
      m_bmask_o = d_bmask_i;
      m_wren_o  = d_we_i && (d_bmask_i != 4'b0000);
    end
  end

  // One-deep read response pipeline; the owner bit steers data to the right port.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsp_valid_q <= 1'b0;
      rsp_dbg_q   <= 1'b0;
    end else begin
      rsp_valid_q <= (c_gnt && !c_we_i) || (d_gnt && !d_we_i);
      rsp_dbg_q   <= d_gnt;
    end
  end

  assign c_gnt_o    = c_gnt;
  assign d_gnt_o    = d_gnt;
  assign starve_o   = starve;
  assign c_rvalid_o = rsp_valid_q && !rsp_dbg_q;
  assign d_rvalid_o = rsp_valid_q && rsp_dbg_q;
  assign c_rdata_o  = c_rvalid_o ? m_rdata_i : 32'h0;
  assign d_rdata_o  = d_rvalid_o ? m_rdata_i : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter: one task per scenario, expected values hand-derived.
module tb_dmem_arbiter;
  import dmem_arbiter_pkg::*;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned STALL_MAX = 15;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              c_req_i, c_we_i, c_gnt_o, c_rvalid_o;
  logic [ADDR_W-1:0] c_addr_i;
  logic [31:0]       c_wdata_i, c_rdata_o;
  logic [3:0]        c_bmask_i;
  logic              d_req_i, d_we_i, d_lock_i, d_gnt_o, d_rvalid_o;
  logic [ADDR_W-1:0] d_addr_i;
  logic [31:0]       d_wdata_i, d_rdata_o;
  logic [3:0]        d_bmask_i;
  logic              m_wren_o, starve_o;
  logic [ADDR_W-1:0] m_addr_o;
  logic [31:0]       m_wdata_o, m_rdata_i;
  logic [3:0]        m_bmask_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(
    .ADDR_W(ADDR_W),
    .STALL_MAX(STALL_MAX)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .c_req_i(c_req_i), .c_we_i(c_we_i), .c_addr_i(c_addr_i), .c_wdata_i(c_wdata_i),
    .c_bmask_i(c_bmask_i), .c_gnt_o(c_gnt_o), .c_rvalid_o(c_rvalid_o), .c_rdata_o(c_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i), .d_wdata_i(d_wdata_i),
    .d_bmask_i(d_bmask_i), .d_lock_i(d_lock_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o),
    .d_rdata_o(d_rdata_o), .m_wren_o(m_wren_o), .m_addr_o(m_addr_o), .m_wdata_o(m_wdata_o),
    .m_bmask_o(m_bmask_o), .m_rdata_i(m_rdata_i), .starve_o(starve_o)
  );

  task automatic clear_inputs();
    c_req_i = 0; c_we_i = 0; c_addr_i = '0; c_wdata_i = '0; c_bmask_i = '0;
    d_req_i = 0; d_we_i = 0; d_addr_i = '0; d_wdata_i = '0; d_bmask_i = '0; d_lock_i = 0;
    m_rdata_i = '0;
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic next_cycle();
    @(posedge clk_i);
    #1;
  endtask

  task automatic test_reset();
    rst_ni = 0;
    clear_inputs();
    c_req_i = 1; d_req_i = 1; c_we_i = 1; c_bmask_i = 4'hF; c_addr_i = 10'h3FF;
    @(negedge clk_i);
    total++; if (c_gnt_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_c_gnt got=%0b want=0", c_gnt_o); end
    total++; if (d_gnt_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_d_gnt got=%0b want=0", d_gnt_o); end
    total++; if (c_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid got=%0b%0b want=00", c_rvalid_o, d_rvalid_o); end
    total++; if (starve_o !== 1'b0) begin bad++; $display("[TB] FAIL reset_starve got=%0b want=0", starve_o); end
    total++; if (m_wren_o !== 1'b0 || m_addr_o !== '0) begin bad++; $display("[TB] FAIL reset_mem got wren=%0b addr=%h want 0/0", m_wren_o, m_addr_o); end
    next_cycle();
    clear_inputs();
    rst_ni = 1;
  endtask

  task automatic test_core_read();
    next_cycle();
    c_req_i = 1; c_we_i = 0; c_addr_i = 10'h010; c_bmask_i = 4'hF;
    @(negedge clk_i);
    total++; if (c_gnt_o !== 1'b1 || d_gnt_o !== 1'b0) begin bad++; $display("[TB] FAIL core_read_gnt got c=%0b d=%0b want c=1 d=0", c_gnt_o, d_gnt_o); end
    total++; if (m_addr_o !== 10'h010 || m_wren_o !== 1'b0) begin bad++; $display("[TB] FAIL core_read_mem got addr=%h wren=%0b want 010/0", m_addr_o, m_wren_o); end
    next_cycle();
    clear_inputs();
    m_rdata_i = 32'hDEADBEEF;
    @(negedge clk_i);
    total++; if (c_rvalid_o !== 1'b1 || c_rdata_o !== 32'hDEADBEEF) begin bad++; $display("[TB] FAIL core_read_rsp got v=%0b d=%h want 1/deadbeef", c_rvalid_o, c_rdata_o); end
    total++; if (d_rvalid_o !== 1'b0 || d_rdata_o !== 32'h0) begin bad++; $display("[TB] FAIL core_read_other got v=%0b d=%h want 0/0", d_rvalid_o, d_rdata_o); end
    next_cycle();
    @(negedge clk_i);
    total++; if (c_rvalid_o !== 1'b0 || c_rdata_o !== 32'h0) begin bad++; $display("[TB] FAIL core_read_after got v=%0b d=%h want 0/0", c_rvalid_o, c_rdata_o); end
    m_rdata_i = '0;
  endtask

  task automatic test_alternate();
    logic exp_c, prev_c;
    logic [ADDR_W-1:0] exp_addr;
    logic [31:0] exp_data;
    for (int i = 0; i < 5; i++) begin
      next_cycle();
      if (i < 4) begin
        c_req_i = 1; c_we_i = 0; c_addr_i = ADDR_W'(32'h100 + i * 4);
        d_req_i = 1; d_we_i = 0; d_addr_i = ADDR_W'(32'h200 + i * 4);
      end else begin
        c_req_i = 0; d_req_i = 0;
      end
      exp_data = 32'hA0000000 + i;
      m_rdata_i = exp_data;
      @(negedge clk_i);
      if (i < 4) begin
        exp_c = (i % 2 == 0);
        exp_addr = exp_c ? ADDR_W'(32'h100 + i * 4) : ADDR_W'(32'h200 + i * 4);
        total++; if (c_gnt_o !== exp_c || d_gnt_o !== !exp_c) begin bad++; $display("[TB] FAIL alt_gnt[%0d] got c=%0b d=%0b want c=%0b", i, c_gnt_o, d_gnt_o, exp_c); end
        total++; if (m_addr_o !== exp_addr) begin bad++; $display("[TB] FAIL alt_addr[%0d] got=%h want=%h", i, m_addr_o, exp_addr); end
      end
      if (i > 0) begin
        prev_c = ((i - 1) % 2 == 0);
        total++; if (c_rvalid_o !== prev_c || d_rvalid_o !== !prev_c) begin bad++; $display("[TB] FAIL alt_rvalid[%0d] got c=%0b d=%0b want c=%0b", i, c_rvalid_o, d_rvalid_o, prev_c); end
        total++; if ((prev_c ? c_rdata_o : d_rdata_o) !== exp_data || (prev_c ? d_rdata_o : c_rdata_o) !== 32'h0) begin bad++; $display("[TB] FAIL alt_rdata[%0d] got c=%h d=%h want %h on owner", i, c_rdata_o, d_rdata_o, exp_data); end
      end
    end
    clear_inputs();
  endtask

  task automatic test_byte_mask();
    next_cycle();
    c_req_i = 1; c_we_i = 1; c_addr_i = 10'h020; c_wdata_i = 32'h12345678; c_bmask_i = 4'b0000;
    @(negedge clk_i);
    total++; if (c_gnt_o !== 1'b1 || m_wren_o !== 1'b0) begin bad++; $display("[TB] FAIL bmask0 got gnt=%0b wren=%0b want 1/0", c_gnt_o, m_wren_o); end
    total++; if (m_wdata_o !== 32'h12345678) begin bad++; $display("[TB] FAIL bmask0_data got=%h want=12345678", m_wdata_o); end
    next_cycle();
    c_bmask_i = 4'b0011; c_wdata_i = 32'h0000BEEF; c_addr_i = 10'h024;
    @(negedge clk_i);
    total++; if (m_wren_o !== 1'b1 || m_bmask_o !== 4'b0011 || m_addr_o !== 10'h024) begin bad++; $display("[TB] FAIL bmask3 got wren=%0b mask=%b addr=%h want 1/0011/024", m_wren_o, m_bmask_o, m_addr_o); end
    next_cycle();
    clear_inputs();
    m_rdata_i = 32'h55555555;
    @(negedge clk_i);
    total++; if (c_rvalid_o !== 1'b0 || d_rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL write_no_rvalid got c=%0b d=%0b want 0/0", c_rvalid_o, d_rvalid_o); end
    total++; if (m_wren_o !== 1'b0 || m_addr_o !== '0 || m_bmask_o !== 4'b0) begin bad++; $display("[TB] FAIL idle_mem got wren=%0b addr=%h mask=%b want 0", m_wren_o, m_addr_o, m_bmask_o); end
    m_rdata_i = '0;
  endtask

  task automatic test_lock_watchdog();
    int dgrants;
    bit found;
    next_cycle();
    d_req_i = 1; d_lock_i = 1; d_we_i = 1; d_addr_i = 10'h300; d_wdata_i = 32'hA5A5A5A5; d_bmask_i = 4'hF;
    @(negedge clk_i);
    total++; if (d_gnt_o !== 1'b1 || m_wren_o !== 1'b1) begin bad++; $display("[TB] FAIL lock_enter got gnt=%0b wren=%0b want 1/1", d_gnt_o, m_wren_o); end
    next_cycle();
    c_req_i = 1; c_we_i = 0; c_addr_i = 10'h040;
    dgrants = 0;
    found = 0;
    for (int n = 0; n < 40 && !found; n++) begin
      @(negedge clk_i);
      if (c_gnt_o === 1'b1) begin
        found = 1;
        total++; if (starve_o !== 1'b1 || d_gnt_o !== 1'b0) begin bad++; $display("[TB] FAIL wdog_override got starve=%0b d_gnt=%0b want 1/0", starve_o, d_gnt_o); end
      end else begin
        if (d_gnt_o === 1'b1) dgrants++;
        total++; if (starve_o !== 1'b0) begin bad++; $display("[TB] FAIL wdog_early_starve[%0d] got=%0b want=0", n, starve_o); end
        next_cycle();
      end
    end
    total++; if (!found) begin bad++; $display("[TB] FAIL wdog_timeout got no core grant want grant within 40 cycles"); end
    total++; if (dgrants != STALL_MAX) begin bad++; $display("[TB] FAIL wdog_dbg_grants got=%0d want=%0d", dgrants, STALL_MAX); end
    next_cycle();
    c_req_i = 0;
    m_rdata_i = 32'h0BADF00D;
    @(negedge clk_i);
    total++; if (dut.state_q !== ARB_CORE) begin bad++; $display("[TB] FAIL wdog_state got=%0d want=%0d", dut.state_q, ARB_CORE); end
    total++; if (c_rvalid_o !== 1'b1 || c_rdata_o !== 32'h0BADF00D) begin bad++; $display("[TB] FAIL wdog_core_rsp got v=%0b d=%h want 1/0badf00d", c_rvalid_o, c_rdata_o); end
    total++; if (starve_o !== 1'b0 || d_gnt_o !== 1'b1) begin bad++; $display("[TB] FAIL wdog_after got starve=%0b d_gnt=%0b want 0/1", starve_o, d_gnt_o); end
    next_cycle();
    clear_inputs();
    @(negedge clk_i);
  endtask

  task automatic test_lock_release();
    next_cycle();
    d_req_i = 1; d_lock_i = 1; d_we_i = 0; d_addr_i = 10'h080;
    @(negedge clk_i);
    total++; if (d_gnt_o !== 1'b1) begin bad++; $display("[TB] FAIL rel_enter got=%0b want=1", d_gnt_o); end
    next_cycle();
    c_req_i = 1; c_we_i = 0; c_addr_i = 10'h084;
    @(negedge clk_i);
    total++; if (d_gnt_o !== 1'b1 || c_gnt_o !== 1'b0) begin bad++; $display("[TB] FAIL rel_locked got c=%0b d=%0b want c=0 d=1", c_gnt_o, d_gnt_o); end
    total++; if (d_rvalid_o !== 1'b1 || c_rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL rel_dbg_rsp got c=%0b d=%0b want c=0 d=1", c_rvalid_o, d_rvalid_o); end
    next_cycle();
    d_lock_i = 0;
    @(negedge clk_i);
    total++; if (c_gnt_o !== 1'b1 || d_gnt_o !== 1'b0 || starve_o !== 1'b0) begin bad++; $display("[TB] FAIL rel_core got c=%0b d=%0b s=%0b want 1/0/0", c_gnt_o, d_gnt_o, starve_o); end
    total++; if (m_addr_o !== 10'h084) begin bad++; $display("[TB] FAIL rel_addr got=%h want=084", m_addr_o); end
    next_cycle();
    c_req_i = 0;
    @(negedge clk_i);
    total++; if (d_gnt_o !== 1'b1 || c_rvalid_o !== 1'b1 || d_rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL rel_after got d_gnt=%0b crv=%0b drv=%0b want 1/1/0", d_gnt_o, c_rvalid_o, d_rvalid_o); end
    next_cycle();
    clear_inputs();
    @(negedge clk_i);
  endtask

  task automatic test_reset_mid_read();
    next_cycle();
    d_req_i = 1; d_we_i = 0; d_addr_i = 10'h0F0;
    @(negedge clk_i);
    total++; if (d_gnt_o !== 1'b1) begin bad++; $display("[TB] FAIL rst_read_gnt got=%0b want=1", d_gnt_o); end
    @(posedge clk_i);
    clear_inputs();
    m_rdata_i = 32'hCAFEF00D;
    rst_ni = 0;
    @(negedge clk_i);
    total++; if (d_rvalid_o !== 1'b0 || d_rdata_o !== 32'h0) begin bad++; $display("[TB] FAIL rst_drop got v=%0b d=%h want 0/0", d_rvalid_o, d_rdata_o); end
    total++; if (c_gnt_o !== 1'b0 || d_gnt_o !== 1'b0 || starve_o !== 1'b0 || m_wren_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_outputs got cg=%0b dg=%0b s=%0b w=%0b want 0", c_gnt_o, d_gnt_o, starve_o, m_wren_o); end
    next_cycle();
    rst_ni = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_i);
      total++; if (d_rvalid_o !== 1'b0 || c_rvalid_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_no_rsp[%0d] got c=%0b d=%0b want 0/0", k, c_rvalid_o, d_rvalid_o); end
      next_cycle();
    end
    c_req_i = 1; d_req_i = 1;
    @(negedge clk_i);
    total++; if (c_gnt_o !== 1'b1 || d_gnt_o !== 1'b0) begin bad++; $display("[TB] FAIL rst_idle_prio got c=%0b d=%0b want 1/0", c_gnt_o, d_gnt_o); end
    next_cycle();
    clear_inputs();
  endtask

  initial begin
    $display("[TB] starting dmem_arbiter bench");
    test_reset();
    test_core_read();
    test_alternate();
    test_byte_mask();
    test_lock_watchdog();
    test_lock_release();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
